seq_alu: RTL and testbench

- Parametrised, multi-cycle arithmetic unit; next generation of the 4-bit `ArithmeticUnit`.
- Operands are `WIDTH` bits wide.
- Adds signed flags, variable shift amounts, arithmetic right shift and an optional iterative multiplier.
- Uses valid/ready handshakes on both sides; sits between the instruction decoder and the register-file writeback.

---
 rtl/seq_alu_if.sv | 28 ++
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 tb/tb_seq_alu.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Handshake and result bundle for seq_alu: operation request side plus result/flag side.
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
    logic             negative;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, carry, overflow, zero, negative, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, carry, overflow, zero, negative, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU (IDLE/EXEC/DONE): add, sub, bit-serial shifts and, when SEQ_ALU_MUL_EN
// is defined, a shift-add multiplier. Without the macro op 101 is treated as illegal.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_LSH = 3'b010;
    localparam logic [2:0] OP_RSH = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b101;
`endif

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [2:0]               op_p0;
    logic signed [WIDTH-1:0]  a_p0;
    logic [WIDTH-1:0]         b_p0;
    logic [CW-1:0]            cnt_p0;

    logic                     accept;
    logic                     last_exec;
    logic signed [WIDTH-1:0]  step;
    logic                     step_c;
    logic [WIDTH-1:0]         res_d;
    logic                     c_d;
    logic                     v_d;
    logic                     ill_d;

`ifdef SEQ_ALU_MUL_EN
    logic [2*WIDTH-1:0]       acc_p0;
    logic [2*WIDTH-1:0]       acc_nxt;
    logic [WIDTH:0]           mul_sum;
`endif

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] != y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Number of EXEC cycles; shifts are clamped to WIDTH and never shorter than one cycle.
    function automatic logic [CW-1:0] exec_len(input logic [2:0] o,
                                               input logic [WIDTH-1:0] amt);
        case (o)
            OP_LSH, OP_RSH, OP_ASR: begin
                if (amt == '0)                  return CW'(1);
                else if (amt >= WIDTH'(WIDTH))  return CW'(WIDTH);
                else                            return amt[CW-1:0];
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL:  return CW'(WIDTH);
`endif
            default: return CW'(1);
        endcase
    endfunction

    assign bus.in_ready = (state == IDLE) && reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_exec    = (state == EXEC) && (cnt_p0 == CW'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    if (last_exec) state_nxt = DONE;
            DONE:    if (bus.out_valid && bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One-bit shift step; a zero shift amount leaves the operand untouched.
    always_comb begin
        step   = a_p0;
        step_c = 1'b0;
        if (b_p0 != '0) begin
            case (op_p0)
                OP_LSH: begin
                    step   = {a_p0[WIDTH-2:0], 1'b0};
                    step_c = a_p0[WIDTH-1];
                end
                OP_RSH: begin
                    step   = {1'b0, a_p0[WIDTH-1:1]};
                    step_c = a_p0[0];
                end
                OP_ASR: begin
                    step   = a_p0 >>> 1;
                    step_c = a_p0[0];
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_ALU_MUL_EN
    assign mul_sum = {1'b0, acc_p0[2*WIDTH-1:WIDTH]} + {1'b0, (acc_p0[0] ? b_p0 : '0)};
    assign acc_nxt = {mul_sum, acc_p0[WIDTH-1:1]};
`endif

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        ill_d = 1'b0;
        case (op_p0)
            OP_ADD: begin
                {c_d, res_d} = {1'b0, a_p0} + {1'b0, b_p0};
                v_d          = add_ovf(a_p0, b_p0, res_d);
            end
            OP_SUB: begin
                res_d = a_p0 - b_p0;
                c_d   = $unsigned(a_p0) < b_p0;
                v_d   = sub_ovf(a_p0, b_p0, res_d);
            end
            OP_LSH, OP_RSH, OP_ASR: begin
                res_d = step;
                c_d   = step_c;
            end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin
                res_d = acc_nxt[WIDTH-1:0];
                c_d   = |acc_nxt[2*WIDTH-1:WIDTH];
            end
`endif
            default: ill_d = 1'b1;
        endcase
    end

    // Stage p0: operation latched at accept, then iterated in place during EXEC.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0  <= bus.op;
            a_p0   <= bus.a;
            b_p0   <= bus.b;
            cnt_p0 <= exec_len(bus.op, bus.b);
`ifdef SEQ_ALU_MUL_EN
            acc_p0 <= {{WIDTH{1'b0}}, bus.a};
`endif
        end else if (state == EXEC) begin
            a_p0   <= step;
            cnt_p0 <= cnt_p0 - CW'(1);
`ifdef SEQ_ALU_MUL_EN
            acc_p0 <= acc_nxt;
`endif
        end
    end

    // Result stage: loaded on the final EXEC cycle and held through DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.zero      <= 1'b0;
            bus.negative  <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (last_exec) begin
            bus.out_valid <= 1'b1;
            bus.result    <= res_d;
            bus.carry     <= c_d;
            bus.overflow  <= v_d;
            bus.zero      <= (res_d == '0);
            bus.negative  <= res_d[WIDTH-1];
            bus.illegal   <= ill_d;
        end else if ((state == DONE) && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu at WIDTH=8 with back-pressure and mid-op reset sequences.
module tb_seq_alu;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
        logic       i;
        logic [4:0] e;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] res, input logic c, input logic v,
                                input logic z, input logic n, input logic i, input logic [4:0] e);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.res = res;
        t.c = c; t.v = v; t.z = z; t.n = n; t.i = i; t.e = e;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        bit got;
        @(negedge clk);
        chk($sformatf("v%0d.in_ready", idx), 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = v.op;
        bus.a = v.a;
        bus.b = v.b;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.op = ~v.op;
            bus.a = ~v.a;
            bus.b = v.b ^ 8'h5A;
            if (bus.out_valid) got = 1'b1;
        end
        chk($sformatf("v%0d.done", idx), 32'(got), 32'd1);
        chk($sformatf("v%0d.latency", idx), 32'(cyc - 1), 32'(v.e));
        chk($sformatf("v%0d.result", idx), 32'(bus.result), 32'(v.res));
        chk($sformatf("v%0d.flags", idx),
            32'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.illegal}),
            32'({v.c, v.v, v.z, v.n, v.i}));
        @(negedge clk);
        chk($sformatf("v%0d.released", idx), 32'({bus.out_valid, bus.in_ready}), 32'b01);
    endtask

    initial begin
        int cyc;
        bit got;
        bit any_valid;

        // op, a, b, result, carry, ovf, zero, neg, illegal, E
        vecs[0]  = mk(3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1);
        vecs[1]  = mk(3'b001, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1);
        vecs[2]  = mk(3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1);
        vecs[3]  = mk(3'b010, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
        vecs[4]  = mk(3'b011, 8'h81, 8'h01, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
        vecs[5]  = mk(3'b100, 8'h80, 8'h09, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd8);
        vecs[6]  = mk(3'b010, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1);
        vecs[7]  = mk(3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
        vecs[8]  = mk(3'b011, 8'h80, 8'h08, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8);
        vecs[9]  = mk(3'b110, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1);
        vecs[10] = mk(3'b100, 8'hC3, 8'h02, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
        vecs[11] = mk(3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1);
`ifdef SEQ_ALU_MUL_EN
        vecs[12] = mk(3'b101, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8);
        vecs[13] = mk(3'b101, 8'h0F, 8'h03, 8'h2D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8);
`else
        vecs[12] = mk(3'b101, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1);
        vecs[13] = mk(3'b101, 8'h0F, 8'h03, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1);
`endif

        bus.in_valid = 1'b0;
        bus.op = 3'b000;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("reset.in_ready", 32'(bus.in_ready), 32'd0);
        chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset.result", 32'(bus.result), 32'd0);
        chk("reset.flags", 32'({bus.carry, bus.overflow, bus.zero, bus.negative, bus.illegal}), 32'd0);
        reset = 1'b1;

        for (int k = 0; k < NV; k++) run_vec(k, vecs[k]);

        // Back-pressure: result must hold and a pending request must wait.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.op = 3'b000;
        bus.a = 8'h01;
        bus.b = 8'h02;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) got = 1'b1;
        end
        chk("bp.latency", 32'(cyc - 1), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = 3'b001;
        bus.a = 8'h10;
        bus.b = 8'h01;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("bp.hold%0d", k),
                32'({bus.out_valid, bus.in_ready, bus.result, bus.carry, bus.zero}),
                32'({1'b1, 1'b0, 8'h03, 1'b0, 1'b0}));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp.after_handshake", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        @(posedge clk);
        @(negedge clk);
        chk("bp.accepted", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("bp.new_result", 32'({bus.out_valid, bus.result, bus.carry, bus.overflow}),
            32'({1'b1, 8'h0F, 1'b0, 1'b0}));
        @(negedge clk);

        // Reset in the middle of a long operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
`ifdef SEQ_ALU_MUL_EN
        bus.op = 3'b101;
        bus.a = 8'h0F;
        bus.b = 8'h03;
`else
        bus.op = 3'b100;
        bus.a = 8'h80;
        bus.b = 8'h08;
`endif
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst.result", 32'(bus.result), 32'd0);
        chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst.release_ready", 32'(bus.in_ready), 32'd1);
        any_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid) any_valid = 1'b1;
        end
        chk("rst.no_result", 32'(any_valid), 32'd0);
        run_vec(100, vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
        $fatal(1, "watchdog expired");
    end
endmodule
